pic_core_param: RTL and testbench

Parametrised, single-clock programmable interrupt controller core: the next generation of the team's 8259-style PIC. It supports a configurable channel count, vector width, per-channel masking, edge or level triggering, fixed or rotating priority, and normal or auto-EOI, and it runs a two-pulse INTA handshake that returns `VEC_BASE + id`. It sits between the peripheral IRQ lines and the CPU interface, and is programmed through a small synchronous register port.

---
 rtl/pic_core_param.sv | 165 ++++++++++++++++
 tb/tb_pic_core_param.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pic_core_param.sv
// rtl/pic_core_param.sv - parametrised 8259-style programmable interrupt controller core
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   irq                : request lines, synchronous to clk
//   wr_en/addr/wdata   : register write port (0 CTRL, 1 VEC_BASE, 2 MASK, 3 EOI)
//   inta_n             : CPU acknowledge, active-low pulses
//   int_o              : registered interrupt request to the CPU
//   vec_out/vec_valid  : vector presented during the second acknowledge pulse
//   irr_o/isr_o        : request and in-service registers
module pic_core_param #(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W   = 8,
    parameter int DW      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               wr_en,
    input  logic [1:0]         addr,
    input  logic [DW-1:0]      wdata,
    input  logic               inta_n,
    output logic               int_o,
    output logic [VEC_W-1:0]   vec_out,
    output logic               vec_valid,
    output logic [NUM_IRQ-1:0] irr_o,
    output logic [NUM_IRQ-1:0] isr_o
);
    localparam int ID_W = $clog2(NUM_IRQ);

    typedef enum logic [1:0] {S_IDLE, S_ACK1, S_ACK2} state_t;

    state_t             r_state;
    logic [NUM_IRQ-1:0] r_irr, r_isr, r_mask, r_irq_prev;
    logic [2:0]         r_ctrl;         // {AEOI, ROT, LTIM}
    logic [VEC_W-1:0]   r_vec_base, r_vec;
    logic [ID_W-1:0]    r_ptr, r_id;
    logic               r_spurious, r_inta_prev, r_int, r_vec_valid;

    logic [NUM_IRQ-1:0] w_req, w_isr_set, w_isr_clr;
    logic [ID_W-1:0]    w_req_id, w_isr_id, w_req_rank, w_isr_rank, w_eoi_id;
    logic               w_req_any, w_isr_any, w_pending, w_inta_fall;
    logic               w_eoi, w_eoi_spec, w_eoi_hit, w_aeoi, w_ack;
    logic               w_unused_ok;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] a, input int b);
        return ID_W'((int'(a) + b) % NUM_IRQ);
    endfunction

    function automatic logic [NUM_IRQ-1:0] onehot(input logic [ID_W-1:0] k);
        return NUM_IRQ'(1) << k;
    endfunction

    assign w_inta_fall = r_inta_prev && !inta_n;
    assign w_unused_ok = &{1'b0, wdata};

    // Priority scan starting at ptr; scanning from the lowest priority upwards
    // lets the last hit be the winner, and its loop index is its rank.
    always_comb begin
        w_req      = r_irr & ~r_mask;
        w_req_any  = 1'b0;
        w_req_id   = '0;
        w_req_rank = '0;
        w_isr_any  = 1'b0;
        w_isr_id   = '0;
        w_isr_rank = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_req[wrap_add(r_ptr, i)]) begin
                w_req_any  = 1'b1;
                w_req_id   = wrap_add(r_ptr, i);
                w_req_rank = ID_W'(i);
            end
            if (r_isr[wrap_add(r_ptr, i)]) begin
                w_isr_any  = 1'b1;
                w_isr_id   = wrap_add(r_ptr, i);
                w_isr_rank = ID_W'(i);
            end
        end
        w_pending = w_req_any && (!w_isr_any || (w_req_rank < w_isr_rank));
    end

    always_comb begin
        w_eoi      = wr_en && (addr == 2'd3);
        w_eoi_spec = wdata[DW-1];
        w_eoi_id   = w_eoi_spec ? wdata[ID_W-1:0] : w_isr_id;
        // Only a clear that actually removes an ISR bit may move the pointer.
        w_eoi_hit  = w_eoi && (w_eoi_spec ?
                     ((int'(wdata[ID_W-1:0]) < NUM_IRQ) && r_isr[wdata[ID_W-1:0]]) :
                     w_isr_any);
        w_aeoi     = (r_state == S_ACK2) && inta_n && r_ctrl[2] && !r_spurious;
        w_ack      = (r_state == S_IDLE) && w_inta_fall;
        w_isr_clr  = '0;
        if (w_eoi_hit) w_isr_clr = w_isr_clr | onehot(w_eoi_id);
        if (w_aeoi)    w_isr_clr = w_isr_clr | onehot(r_id);
        w_isr_set  = (w_ack && w_pending) ? onehot(w_req_id) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_irr       <= '0;
            r_isr       <= '0;
            r_mask      <= '1;
            r_irq_prev  <= '0;
            r_ctrl      <= '0;
            r_vec_base  <= '0;
            r_vec       <= '0;
            r_ptr       <= '0;
            r_id        <= '0;
            r_spurious  <= 1'b0;
            r_inta_prev <= 1'b1;
            r_int       <= 1'b0;
            r_vec_valid <= 1'b0;
        end else begin
            r_irq_prev  <= irq;
            r_inta_prev <= inta_n;

            // Edge mode: a fresh edge beats the acknowledge clear on the same bit.
            if (r_ctrl[0]) r_irr <= irq;
            else           r_irr <= (r_irr & ~w_isr_set) | (irq & ~r_irq_prev);

            r_isr <= (r_isr & ~w_isr_clr) | w_isr_set;

            if (wr_en) begin
                case (addr)
                    2'd0:    r_ctrl     <= wdata[2:0];
                    2'd1:    r_vec_base <= wdata[VEC_W-1:0];
                    2'd2:    r_mask     <= wdata[NUM_IRQ-1:0];
                    default: ;
                endcase
            end

            if (!r_ctrl[1])     r_ptr <= '0;
            else if (w_aeoi)    r_ptr <= wrap_add(r_id, 1);
            else if (w_eoi_hit) r_ptr <= wrap_add(w_eoi_id, 1);

            // int_o is held low for the whole handshake, including its first cycle.
            r_int <= (r_state == S_IDLE && !w_inta_fall) ? w_pending : 1'b0;

            case (r_state)
                S_IDLE: if (w_inta_fall) begin
                    r_state    <= S_ACK1;
                    r_spurious <= !w_pending;
                    r_id       <= w_pending ? w_req_id : ID_W'(NUM_IRQ - 1);
                end
                S_ACK1: if (w_inta_fall) begin
                    r_state     <= S_ACK2;
                    r_vec       <= r_vec_base + VEC_W'(r_id);
                    r_vec_valid <= 1'b1;
                end
                S_ACK2: if (inta_n) begin
                    r_state     <= S_IDLE;
                    r_vec_valid <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign int_o     = r_int;
    assign vec_out   = r_vec;
    assign vec_valid = r_vec_valid;
    assign irr_o     = r_irr;
    assign isr_o     = r_isr;
endmodule

// File: tb/tb_pic_core_param.sv
// tb/tb_pic_core_param.sv - directed-vector bench for pic_core_param
module tb_pic_core_param;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  irq = '0;
    logic        wr_en = 1'b0;
    logic [1:0]  addr = '0;
    logic [15:0] wdata = '0;
    logic        inta_n = 1'b1;
    logic        int_o;
    logic [7:0]  vec_out;
    logic        vec_valid;
    logic [7:0]  irr_o, isr_o;

    int n_vec = 0;
    int n_err = 0;

    pic_core_param #(.NUM_IRQ(8), .VEC_W(8), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .irq(irq), .wr_en(wr_en), .addr(addr),
        .wdata(wdata), .inta_n(inta_n), .int_o(int_o), .vec_out(vec_out),
        .vec_valid(vec_valid), .irr_o(irr_o), .isr_o(isr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ctrl;
        logic [7:0] mask;
        logic [7:0] base;
        logic [7:0] irq;
        logic       exp_int;
        logic [7:0] exp_vec;
        logic [7:0] exp_isr;
        logic [7:0] exp_irr;
        logic [7:0] exp_isr_eoi;
    } vec_t;

    vec_t tbl[7];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; irq = '0; inta_n = 1'b1; wr_en = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        tick(1);
        wr_en = 1'b0;
    endtask

    // Two acknowledge pulses, each two cycles low and two high; the vector is
    // sampled during the second low pulse.
    task automatic inta(output logic [7:0] v, output logic vv);
        inta_n = 1'b0; tick(2);
        inta_n = 1'b1; tick(2);
        inta_n = 1'b0; tick(1);
        v = vec_out; vv = vec_valid;
        tick(1);
        inta_n = 1'b1; tick(1);
    endtask

    initial begin
        logic [7:0] v;
        logic       vv;

        //           ctrl  mask   base   irq    int   vec    isr    irr    isr_eoi
        tbl[0] = '{3'd0, 8'h00, 8'h20, 8'h10, 1'b1, 8'h24, 8'h10, 8'h00, 8'h00};
        tbl[1] = '{3'd0, 8'h00, 8'h40, 8'h81, 1'b1, 8'h40, 8'h01, 8'h80, 8'h00};
        tbl[2] = '{3'd0, 8'h01, 8'h40, 8'h81, 1'b1, 8'h47, 8'h80, 8'h01, 8'h00};
        tbl[3] = '{3'd1, 8'h00, 8'h10, 8'h0C, 1'b1, 8'h12, 8'h04, 8'h0C, 8'h00};
        tbl[4] = '{3'd0, 8'h00, 8'hFE, 8'h08, 1'b1, 8'h01, 8'h08, 8'h00, 8'h00};
        tbl[5] = '{3'd4, 8'hFE, 8'h30, 8'h03, 1'b1, 8'h30, 8'h00, 8'h02, 8'h00};
        tbl[6] = '{3'd0, 8'hFF, 8'h50, 8'h01, 1'b0, 8'h57, 8'h00, 8'h01, 8'h00};

        do_reset();
        check("rst_int",   32'(int_o),     32'h0);
        check("rst_valid", 32'(vec_valid), 32'h0);
        check("rst_vec",   32'(vec_out),   32'h0);
        check("rst_irr",   32'(irr_o),     32'h0);
        check("rst_isr",   32'(isr_o),     32'h0);

        for (int k = 0; k < 7; k++) begin
            do_reset();
            wr(2'd0, 16'(tbl[k].ctrl));
            wr(2'd2, 16'(tbl[k].mask));
            wr(2'd1, 16'(tbl[k].base));
            irq = tbl[k].irq;
            tick(2);
            check($sformatf("v%0d_int", k),   32'(int_o), 32'(tbl[k].exp_int));
            inta(v, vv);
            check($sformatf("v%0d_valid", k), 32'(vv),    32'h1);
            check($sformatf("v%0d_vec", k),   32'(v),     32'(tbl[k].exp_vec));
            check($sformatf("v%0d_isr", k),   32'(isr_o), 32'(tbl[k].exp_isr));
            check($sformatf("v%0d_irr", k),   32'(irr_o), 32'(tbl[k].exp_irr));
            tick(1);
            check($sformatf("v%0d_int_after", k), 32'(int_o), 32'h0);
            wr(2'd3, 16'h0000);
            check($sformatf("v%0d_isr_eoi", k), 32'(isr_o), 32'(tbl[k].exp_isr_eoi));
        end

        // Nesting: lower-priority requests wait behind ISR[4]; a higher one interrupts it.
        do_reset();
        wr(2'd2, 16'h0000);
        wr(2'd1, 16'h0020);
        irq = 8'h10; tick(2);
        inta(v, vv);
        check("nest_isr4", 32'(isr_o), 32'h10);
        irq = 8'hD0; tick(3);
        check("nest_blocked", 32'(int_o), 32'h0);
        irq = 8'hD2; tick(2);
        check("nest_int", 32'(int_o), 32'h1);
        inta(v, vv);
        check("nest_vec", 32'(v), 32'h21);
        check("nest_isr", 32'(isr_o), 32'h12);
        wr(2'd3, 16'h8004);
        check("spec_eoi", 32'(isr_o), 32'h02);
        wr(2'd3, 16'h0000);
        check("nonspec_eoi", 32'(isr_o), 32'h00);

        // Rotation: after channel 0 is serviced, channel 3 outranks it.
        do_reset();
        wr(2'd0, 16'h0002);
        wr(2'd2, 16'h0000);
        irq = 8'h09; tick(3);
        inta(v, vv);
        check("rot_vec0", 32'(v), 32'h00);
        wr(2'd3, 16'h0000);
        check("rot_eoi", 32'(isr_o), 32'h00);
        irq = 8'h08; tick(1);
        irq = 8'h09; tick(2);
        check("rot_irr", 32'(irr_o), 32'h09);
        inta(v, vv);
        check("rot_vec3", 32'(v), 32'h03);
        check("rot_isr", 32'(isr_o), 32'h08);

        // Spurious: level request withdrawn before the first acknowledge.
        do_reset();
        wr(2'd0, 16'h0001);
        wr(2'd2, 16'h0000);
        wr(2'd1, 16'h0060);
        irq = 8'h04; tick(2);
        check("spur_int", 32'(int_o), 32'h1);
        irq = 8'h00; tick(1);
        inta(v, vv);
        check("spur_vec", 32'(v), 32'h67);
        check("spur_isr", 32'(isr_o), 32'h00);

        // Asynchronous reset while in ACK1.
        do_reset();
        wr(2'd2, 16'h0000);
        wr(2'd1, 16'h0020);
        irq = 8'h02; tick(2);
        inta(v, vv);
        check("mid_vec", 32'(v), 32'h21);
        irq = 8'h03; tick(2);
        inta_n = 1'b0; tick(2);
        check("mid_isr", 32'(isr_o), 32'h03);
        rst_n = 1'b0;
        #1;
        check("mid_rst_int",   32'(int_o),     32'h0);
        check("mid_rst_vec",   32'(vec_out),   32'h0);
        check("mid_rst_valid", 32'(vec_valid), 32'h0);
        check("mid_rst_isr",   32'(isr_o),     32'h0);
        check("mid_rst_irr",   32'(irr_o),     32'h0);
        tick(1);
        inta_n = 1'b1; irq = 8'h00;
        rst_n = 1'b1;
        tick(1);
        irq = 8'h01; tick(3);
        check("mid_mask_ones", 32'(int_o), 32'h0);
        wr(2'd2, 16'h0000);
        tick(1);
        check("mid_unmask_int", 32'(int_o), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
